inst_rom_resp: RTL and testbench

Instruction-memory responder for the core's fetch port: answers `rom_ce`/`rom_addr` requests with `rom_data`, sourcing instruction words from a byte-wide external memory bus. A hit in its one-word holding buffer is answered in the same cycle. On a miss it raises a stall request to `ctrl`, beside the existing ID and EX requests, and fetches the four bytes. It sits between the core top and the board-level program memory, replacing a flat single-cycle ROM.

---
 rtl/inst_rom_resp.sv | 205 ++++++++++++++++++++
 tb/tb_inst_rom_resp.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_resp.sv
// inst_rom_resp: instruction-fetch responder with a one-word holding buffer.
// A buffer hit is answered combinationally; a miss stalls the core and
// assembles the word from four big-endian reads on a byte-wide external bus.
// Optional feature macro: INST_ROM_PREFETCH_EN adds a second word buffer that
// is filled with the next sequential word after every fill.
module inst_rom_resp #(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    output logic              stallreq_o,
    output logic              ext_req_o,
    output logic [ADDR_W-1:0] ext_addr_o,
    input  logic              ext_ack_i,
    input  logic [7:0]        ext_data_i
);

    localparam int TAG_W = ADDR_W - 2;

`ifdef INST_ROM_PREFETCH_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILL     = 2'd1,
        ST_PREFETCH = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1
    } state_t;
`endif

    state_t             state;
    state_t             state_next;

    // Main holding buffer
    logic [TAG_W-1:0]   buf_tag;
    logic [31:0]        buf_data;
    logic               buf_vld;

    // Fill engine: word tag being fetched, byte index, first three bytes
    logic [TAG_W-1:0]   fill_tag;
    logic [1:0]         bcnt;
    logic [23:0]        asm_sr;

    logic [TAG_W-1:0]   req_tag;
    logic               buf_hit;
    logic               fill_start;
    logic               byte_take;
    logic               word_done;
    logic               unused_addr_bits;

`ifdef INST_ROM_PREFETCH_EN
    // Prefetch buffer for the word following the last filled one
    logic [TAG_W-1:0]   pf_tag;
    logic [31:0]        pf_data;
    logic               pf_vld;
    logic               pf_hit;
    logic               pf_promote;
`endif

    // Only word-address bits inside the external space form the tag
    assign req_tag          = rom_addr_i[ADDR_W-1:2];
    assign unused_addr_bits = ^{rom_addr_i[31:ADDR_W], rom_addr_i[1:0]};
    assign buf_hit          = buf_vld && (buf_tag == req_tag);
`ifdef INST_ROM_PREFETCH_EN
    assign pf_hit           = pf_vld && (pf_tag == req_tag);
`endif

    // State register; reset drops the bus request immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, fetch-port answer and external bus drive
    always_comb begin
        state_next = state;
        fill_start = 1'b0;
        rom_data_o = 32'h0;
        stallreq_o = 1'b0;
        ext_req_o  = 1'b0;
        ext_addr_o = '0;
`ifdef INST_ROM_PREFETCH_EN
        pf_promote = 1'b0;
`endif

        // Any non-idle state owns the external bus
        if (state != ST_IDLE) begin
            ext_req_o  = 1'b1;
            ext_addr_o = {fill_tag, bcnt};
        end
        byte_take = ext_req_o && ext_ack_i;
        word_done = byte_take && (bcnt == 2'd3);

        // Fetch port: main buffer first, then prefetch buffer, else stall
        if (rom_ce_i) begin
            if (buf_hit) begin
                rom_data_o = buf_data;
`ifdef INST_ROM_PREFETCH_EN
            end else if (pf_hit) begin
                rom_data_o = pf_data;
`endif
            end else begin
                stallreq_o = 1'b1;
            end
        end

        case (state)
            ST_IDLE: begin
                if (rom_ce_i && stallreq_o) begin
                    fill_start = 1'b1;
                    state_next = ST_FILL;
`ifdef INST_ROM_PREFETCH_EN
                end else if (rom_ce_i && !buf_hit && pf_hit) begin
                    pf_promote = 1'b1;
                    state_next = ST_PREFETCH;
`endif
                end
            end
            ST_FILL: begin
                if (word_done) begin
`ifdef INST_ROM_PREFETCH_EN
                    state_next = ST_PREFETCH;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
`ifdef INST_ROM_PREFETCH_EN
            ST_PREFETCH: begin
                if (word_done) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Fill datapath: byte capture, word commit and buffer bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_tag  <= '0;
            buf_data <= 32'h0;
            buf_vld  <= 1'b0;
            fill_tag <= '0;
            bcnt     <= 2'd0;
            asm_sr   <= 24'h0;
`ifdef INST_ROM_PREFETCH_EN
            pf_tag   <= '0;
            pf_data  <= 32'h0;
            pf_vld   <= 1'b0;
`endif
        end else begin
            if (fill_start) begin
                fill_tag <= req_tag;
                bcnt     <= 2'd0;
            end
            // Big-endian assembly: first byte ends up in [31:24]
            if (byte_take) begin
                asm_sr <= {asm_sr[15:0], ext_data_i};
                bcnt   <= bcnt + 2'd1;
            end
            if (word_done && (state == ST_FILL)) begin
                buf_data <= {asm_sr, ext_data_i};
                buf_tag  <= fill_tag;
                buf_vld  <= 1'b1;
            end
`ifdef INST_ROM_PREFETCH_EN
            // A demand fill invalidates the stale prefetch word
            if (fill_start) begin
                pf_vld <= 1'b0;
            end
            // After a demand fill, continue with the next sequential word
            if (word_done && (state == ST_FILL)) begin
                fill_tag <= fill_tag + TAG_W'(1);
            end
            if (word_done && (state == ST_PREFETCH)) begin
                pf_data <= {asm_sr, ext_data_i};
                pf_tag  <= fill_tag;
                pf_vld  <= 1'b1;
            end
            // Prefetch hit: promote into the main buffer, fetch the word after it
            if (pf_promote) begin
                buf_data <= pf_data;
                buf_tag  <= pf_tag;
                buf_vld  <= 1'b1;
                pf_vld   <= 1'b0;
                fill_tag <= pf_tag + TAG_W'(1);
                bcnt     <= 2'd0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed testbench for inst_rom_resp with a byte-wide memory responder
// whose ack latency is programmable per phase.
module tb_inst_rom_resp;

    localparam int ADDR_W = 20;

    logic              clk;
    logic              rst;
    logic              rom_ce;
    logic [31:0]       rom_addr;
    logic [31:0]       rom_data;
    logic              stallreq;
    logic              ext_req;
    logic [ADDR_W-1:0] ext_addr;
    logic              ext_ack;
    logic [7:0]        ext_data;

    logic [7:0]        mem [0:255];
    int unsigned       wait_cfg;
    int unsigned       wcnt;
    int                n_cmp;
    int                n_err;

    inst_rom_resp #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce),
        .rom_addr_i (rom_addr),
        .rom_data_o (rom_data),
        .stallreq_o (stallreq),
        .ext_req_o  (ext_req),
        .ext_addr_o (ext_addr),
        .ext_ack_i  (ext_ack),
        .ext_data_i (ext_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: acks after wait_cfg idle request cycles
    always @(posedge clk) begin
        if (!ext_req || ext_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end
    assign ext_ack  = ext_req && (wcnt >= wait_cfg);
    assign ext_data = mem[ext_addr[7:0]];

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h required=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        wcnt  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[0]  = 8'h11; mem[1]  = 8'h22; mem[2]  = 8'h33; mem[3]  = 8'h44;
        mem[4]  = 8'h55; mem[5]  = 8'h66; mem[6]  = 8'h77; mem[7]  = 8'h88;
        mem[8]  = 8'h99; mem[9]  = 8'hAA; mem[10] = 8'hBB; mem[11] = 8'hCC;
        mem[16] = 8'hDE; mem[17] = 8'hAD; mem[18] = 8'hBE; mem[19] = 8'hEF;

        rst = 1'b1; rom_ce = 1'b0; rom_addr = 32'h0; wait_cfg = 0;
        tick(); tick();
        #1;
        chk("rst_data",  rom_data, 32'h0);
        chk("rst_stall", 32'(stallreq), 32'h0);
        chk("rst_req",   32'(ext_req), 32'h0);
        chk("rst_addr",  32'(ext_addr), 32'h0);
        tick();

        // ce low: no answer, no stall, no fill
        rst = 1'b0; rom_ce = 1'b0; rom_addr = 32'h0;
        #1;
        chk("ce0_data",  rom_data, 32'h0);
        chk("ce0_stall", 32'(stallreq), 32'h0);
        tick();
        #1;
        chk("ce0_req", 32'(ext_req), 32'h0);
        tick();

`ifdef INST_ROM_PREFETCH_EN
        // Demand fill of 0x0 followed by automatic prefetch of 0x4
        rom_ce = 1'b1; rom_addr = 32'h0;
        #1;
        chk("pf_miss_stall", 32'(stallreq), 32'h1);
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("pf_fill_addr",  32'(ext_addr), 32'(k));
            chk("pf_fill_stall", 32'(stallreq), 32'h1);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("pf_hit0_data",  rom_data, 32'h11223344);
            chk("pf_hit0_stall", 32'(stallreq), 32'h0);
            chk("pf_pref_req",   32'(ext_req), 32'h1);
            chk("pf_pref_addr",  32'(ext_addr), 32'(4 + k));
            tick();
        end
        rom_addr = 32'h4;
        #1;
        chk("pf_hit4_data",  rom_data, 32'h55667788);
        chk("pf_hit4_stall", 32'(stallreq), 32'h0);
        chk("pf_hit4_req",   32'(ext_req), 32'h0);
        tick();
        #1;
        chk("pf_main4_data", rom_data, 32'h55667788);
        chk("pf_next_req",   32'(ext_req), 32'h1);
        chk("pf_next_addr",  32'(ext_addr), 32'h8);
        tick();
`else
        // Zero-wait miss on 0x0: five stall cycles, then a hit
        rom_ce = 1'b1; rom_addr = 32'h0;
        #1;
        chk("miss_stall", 32'(stallreq), 32'h1);
        chk("miss_data",  rom_data, 32'h0);
        chk("miss_req",   32'(ext_req), 32'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fill_stall", 32'(stallreq), 32'h1);
            chk("fill_req",   32'(ext_req), 32'h1);
            chk("fill_addr",  32'(ext_addr), 32'(k));
            tick();
        end
        #1;
        chk("hit_data",  rom_data, 32'h11223344);
        chk("hit_stall", 32'(stallreq), 32'h0);
        chk("hit_req",   32'(ext_req), 32'h0);
        tick();

        // Unaligned address within the buffered word
        rom_addr = 32'h2;
        #1;
        chk("unal_data",  rom_data, 32'h11223344);
        chk("unal_stall", 32'(stallreq), 32'h0);
        tick();
        #1;
        chk("unal_req", 32'(ext_req), 32'h0);
        tick();

        // Three cycles per byte: 13 stall cycles, address held while waiting
        wait_cfg = 2; rom_addr = 32'h10;
        #1;
        chk("slow_miss_stall", 32'(stallreq), 32'h1);
        tick();
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("slow_stall", 32'(stallreq), 32'h1);
            chk("slow_addr",  32'(ext_addr), 32'(16 + c / 3));
            tick();
        end
        #1;
        chk("slow_data",  rom_data, 32'hDEADBEEF);
        chk("slow_stall_end", 32'(stallreq), 32'h0);
        tick();

        // Address change after two acks: old fill completes, then new fill
        wait_cfg = 0; rom_addr = 32'h0;
        #1;
        chk("mid_miss_stall", 32'(stallreq), 32'h1);
        tick();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("mid_addr_a", 32'(ext_addr), 32'(k));
            tick();
        end
        rom_addr = 32'h8;
        for (int k = 2; k < 4; k++) begin
            #1;
            chk("mid_addr_b",  32'(ext_addr), 32'(k));
            chk("mid_stall_b", 32'(stallreq), 32'h1);
            tick();
        end
        rom_addr = 32'h0;
        #1;
        chk("mid_old_data",  rom_data, 32'h11223344);
        chk("mid_old_stall", 32'(stallreq), 32'h0);
        chk("mid_old_req",   32'(ext_req), 32'h0);
        tick();
        rom_addr = 32'h8;
        #1;
        chk("mid_new_stall", 32'(stallreq), 32'h1);
        chk("mid_new_req0",  32'(ext_req), 32'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("mid_new_req",  32'(ext_req), 32'h1);
            chk("mid_new_addr", 32'(ext_addr), 32'(8 + k));
            tick();
        end
        #1;
        chk("mid_new_data", rom_data, 32'h99AABBCC);
        chk("mid_new_hit",  32'(stallreq), 32'h0);
        tick();

        // Reset after one ack: request drops at once, word refetched
        rom_addr = 32'h0;
        #1;
        chk("rf_miss_stall", 32'(stallreq), 32'h1);
        tick();
        #1;
        chk("rf_addr0", 32'(ext_addr), 32'h0);
        tick();
        #1;
        chk("rf_addr1", 32'(ext_addr), 32'h1);
        rst = 1'b1;
        #1;
        chk("rf_req_drop",  32'(ext_req), 32'h0);
        chk("rf_addr_zero", 32'(ext_addr), 32'h0);
        chk("rf_data_zero", rom_data, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rf_re_stall", 32'(stallreq), 32'h1);
        chk("rf_re_req",   32'(ext_req), 32'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rf_re_addr", 32'(ext_addr), 32'(k));
            tick();
        end
        #1;
        chk("rf_re_data",  rom_data, 32'h11223344);
        chk("rf_re_stall_end", 32'(stallreq), 32'h0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
